// File: rtl/scc_isa_pkg.sv
// Shared ISA definitions for the SCC core pipeline.
//
// Purpose: opcode constants, condition-code encoding, instruction field
// bit positions, the decode-stage state enum and the uses_rs2() helper.
//
// Instruction word layout (32 bits):
//   [31:25] opcode  [24:22] rd / cond  [21:19] rs1  [18:16] rs2  [15:0] imm
package scc_isa_pkg;

  // Opcodes
  localparam logic [6:0] OP_B     = 7'b1100000;  // unconditional, resolved in fetch
  localparam logic [6:0] OP_BCOND = 7'b1100001;  // conditional, resolved in decode
  localparam logic [6:0] OP_BR    = 7'b1100010;  // register branch, resolved in fetch
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;  // register-register ALU group is 011xxxx

  // Field positions and widths
  localparam int OPC_LSB = 25;
  localparam int OPC_W   = 7;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 19;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 16;
  localparam int COND_W  = 3;

  // Branch / predicate condition codes, carried in the rd field
  typedef enum logic [2:0] {
    COND_EQ = 3'b000,
    COND_NE = 3'b001,
    COND_LT = 3'b010,
    COND_GE = 3'b011,
    COND_CS = 3'b100,
    COND_CC = 3'b101,
    COND_MI = 3'b110,
    COND_AL = 3'b111
  } cond_t;

  // Decode stage states
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } id_state_t;

  // True when the opcode reads rs2: stores and the register-register ALU
  // group. Loads, immediates and branches leave rs2 as don't-care bits.
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OP_ST) || (opcode[6:4] == 3'b011);
  endfunction

endpackage

// File: rtl/id_cond_eval.sv
// Condition evaluator.
//
// Purpose: combinational (cond, flags) -> taken. Shared by conditional
// branches in decode and by predicated instructions.
//
// Ports:
//   cond   in  3  condition code (cond_t encoding)
//   flags  in  4  {N,Z,C,V}
//   taken  out 1  condition holds
module id_cond_eval
  import scc_isa_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n_flag, z_flag, c_flag, v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      COND_EQ: taken = z_flag;
      COND_NE: taken = !z_flag;
      COND_LT: taken = n_flag != v_flag;
      COND_GE: taken = n_flag == v_flag;
      COND_CS: taken = c_flag;
      COND_CC: taken = !c_flag;
      COND_MI: taken = n_flag;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_decode.sv
// Instruction Decode stage.
//
// Purpose: registers the IF/ID boundary, splits instruction fields for
// execute, resolves conditional branches (BCOND) against flags and
// redirects fetch, inserts a one-cycle bubble on a load-use hazard and
// squashes the FLUSH_DEPTH valid instructions fetched behind a taken
// branch.
//
// Ports:
//   clk, reset (synchronous, active high)
//   instr_in, instr_valid_in, pc_in, flags_in   from fetch / special regs
//   stall_out                                   combinational hold to fetch
//   valid_out, opcode_out, rd_out, rs1_out,
//   rs2_out, imm_out, pc_out                    decoded outputs to execute
//   br_taken, br_target                         redirect pulse to fetch
//
// Optional: define ID_PERF_CNT_EN to add issued_cnt / bubble_cnt
// (32-bit wrapping counters of issued instructions and of bubbles plus
// squashed instructions).
//
// REG_AW must match the 3-bit register fields of the encoding.
module id_decode
  import scc_isa_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 3,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              instr_valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        flags_in,
  output logic              stall_out,
  output logic              valid_out,
  output logic [6:0]        opcode_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [REG_AW-1:0] rs1_out,
  output logic [REG_AW-1:0] rs2_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_target
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]       issued_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  id_state_t         state;
  logic [1:0]        flush_cnt;

  logic [6:0]        op_in;
  logic [REG_AW-1:0] rd_in;
  logic [REG_AW-1:0] rs1_in;
  logic [REG_AW-1:0] rs2_in;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] target_sum;
  logic              cond_taken;
  logic              hazard;
  logic              issue;
  logic              squash;

  assign op_in      = instr_in[OPC_LSB +: OPC_W];
  assign rd_in      = instr_in[RD_LSB  +: REG_AW];
  assign rs1_in     = instr_in[RS1_LSB +: REG_AW];
  assign rs2_in     = instr_in[RS2_LSB +: REG_AW];
  assign imm_sext   = {{(DATA_W-IMM_W){instr_in[IMM_LSB+IMM_W-1]}}, instr_in[IMM_LSB +: IMM_W]};
  assign target_sum = pc_in + imm_sext;

  id_cond_eval u_cond_eval (
    .cond  (instr_in[RD_LSB +: COND_W]),
    .flags (flags_in),
    .taken (cond_taken)
  );

  // Load-use check runs only in RUN: STALL re-presents the held
  // instruction behind a bubble, and FLUSH discards whatever arrives.
  assign hazard = (state == RUN) && valid_out && (opcode_out == OP_LD) && instr_valid_in &&
                  ((rs1_in == rd_out) || (uses_rs2(op_in) && (rs2_in == rd_out)));

  assign stall_out = hazard && !reset;

  // The instruction held across STALL is accepted like any RUN-state one.
  assign issue  = instr_valid_in && !hazard && (state != FLUSH);
  assign squash = instr_valid_in && (state == FLUSH);

  // Pipeline register and control state. br_taken defaults low so it
  // pulses for exactly one cycle; field outputs only move on issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      flush_cnt  <= 2'd0;
      valid_out  <= 1'b0;
      opcode_out <= '0;
      rd_out     <= '0;
      rs1_out    <= '0;
      rs2_out    <= '0;
      imm_out    <= '0;
      pc_out     <= '0;
      br_taken   <= 1'b0;
      br_target  <= '0;
    end else begin
      br_taken  <= 1'b0;
      valid_out <= 1'b0;
      case (state)
        RUN, STALL: begin
          if (hazard) begin
            state <= STALL;
          end else begin
            state <= RUN;
            if (issue) begin
              valid_out  <= 1'b1;
              opcode_out <= op_in;
              rd_out     <= rd_in;
              rs1_out    <= rs1_in;
              rs2_out    <= rs2_in;
              imm_out    <= imm_sext;
              pc_out     <= pc_in;
              if ((op_in == OP_BCOND) && cond_taken) begin
                br_taken  <= 1'b1;
                br_target <= {target_sum[DATA_W-1:2], 2'b00};
                flush_cnt <= 2'(FLUSH_DEPTH);
                state     <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (squash) begin
            flush_cnt <= flush_cnt - 2'd1;
            if (flush_cnt == 2'd1) begin
              state <= RUN;
            end
          end
        end
        default: begin
          state     <= RUN;
          flush_cnt <= 2'd0;
        end
      endcase
    end
  end

`ifdef ID_PERF_CNT_EN
  // Counters step on the same edge that produces the counted event.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (issue) begin
        issued_cnt <= issued_cnt + 32'd1;
      end
      if (hazard || squash) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_decode.sv
// Self-checking bench for id_decode: directed scenarios plus randomized
// traffic checked against a behavioural model of the decode rules.
module tb_id_decode;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  localparam logic [6:0] T_LD    = 7'b0000011;
  localparam logic [6:0] T_ST    = 7'b0100011;
  localparam logic [6:0] T_ADD   = 7'b0110011;
  localparam logic [6:0] T_ADDI  = 7'b0010011;
  localparam logic [6:0] T_B     = 7'b1100000;
  localparam logic [6:0] T_BCOND = 7'b1100001;
  localparam logic [6:0] T_BR    = 7'b1100010;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] instr_in;
  logic          instr_valid_in;
  logic [DW-1:0] pc_in;
  logic [3:0]    flags_in;
  logic          stall_out;
  logic          valid_out;
  logic [6:0]    opcode_out;
  logic [2:0]    rd_out, rs1_out, rs2_out;
  logic [DW-1:0] imm_out, pc_out, br_target;
  logic          br_taken;
`ifdef ID_PERF_CNT_EN
  logic [31:0]   issued_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state
  logic          m_valid, m_br;
  logic [6:0]    m_op;
  logic [2:0]    m_rd, m_rs1, m_rs2;
  logic [DW-1:0] m_imm, m_pc, m_tgt;
  int            m_squash;
  logic          m_bubbled;
  int            m_issued, m_bubbles;
  logic          exp_stall, obs_stall;

  id_decode #(.DATA_W(DW), .REG_AW(3), .FLUSH_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_in       (instr_in),
    .instr_valid_in (instr_valid_in),
    .pc_in          (pc_in),
    .flags_in       (flags_in),
    .stall_out      (stall_out),
    .valid_out      (valid_out),
    .opcode_out     (opcode_out),
    .rd_out         (rd_out),
    .rs1_out        (rs1_out),
    .rs2_out        (rs2_out),
    .imm_out        (imm_out),
    .pc_out         (pc_out),
    .br_taken       (br_taken),
    .br_target      (br_target)
`ifdef ID_PERF_CNT_EN
    ,
    .issued_cnt     (issued_cnt),
    .bubble_cnt     (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == T_ST) || (op == T_ADD) || (op[6:4] == 3'b011);
  endfunction

  function automatic logic cond_true(input logic [2:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return n ^ v;
      3'd3: return !(n ^ v);
      3'd4: return cy;
      3'd5: return !cy;
      3'd6: return n;
      default: return 1'b1;
    endcase
  endfunction

  // Drive one cycle of inputs, sample stall_out mid-cycle, advance the
  // model across the clock edge, and leave time 1 unit after the edge.
  task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [3:0] fl);
    logic [6:0] op;
    logic [2:0] rs1, rs2;
    logic [31:0] sext;
    reset = rst; instr_valid_in = v; instr_in = ins; pc_in = pc; flags_in = fl;
    op   = ins[31:25];
    rs1  = ins[21:19];
    rs2  = ins[18:16];
    sext = {{16{ins[15]}}, ins[15:0]};
    #1;
    exp_stall = !rst && (m_squash == 0) && !m_bubbled && m_valid && (m_op == T_LD) && v &&
                ((rs1 == m_rd) || (reads_rs2(op) && (rs2 == m_rd)));
    obs_stall = stall_out;
    if (rst) begin
      m_valid = 0; m_br = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
      m_imm = 0; m_pc = 0; m_tgt = 0; m_squash = 0; m_bubbled = 0;
      m_issued = 0; m_bubbles = 0;
    end else begin
      m_br = 0;
      if (exp_stall) begin
        m_valid = 0; m_bubbled = 1; m_bubbles++;
      end else if (m_squash > 0) begin
        m_valid = 0;
        if (v) begin m_squash--; m_bubbles++; end
      end else begin
        m_bubbled = 0;
        m_valid   = v;
        if (v) begin
          m_op = op; m_rd = ins[24:22]; m_rs1 = rs1; m_rs2 = rs2;
          m_imm = sext; m_pc = pc; m_issued++;
          if (op == T_BCOND && cond_true(ins[24:22], fl)) begin
            m_br = 1; m_tgt = (pc + sext) & ~32'd3; m_squash = DEPTH;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", obs_stall); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (br_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_br_taken: got %b expected 0", br_taken); end
    checks++; if (br_target !== 32'h0) begin errors++; $display("[TB] FAIL reset_br_target: got %h expected 0", br_target); end
    checks++;
    if ({opcode_out, rd_out, rs1_out, rs2_out, imm_out, pc_out} !== '0) begin
      errors++; $display("[TB] FAIL reset_fields: got op=%h rd=%h imm=%h pc=%h expected all 0", opcode_out, rd_out, imm_out, pc_out);
    end
  endtask

  task automatic test_load_use();
    step(0, 0, 0, 0, 0);
    step(0, 1, enc(T_LD, 3'd3, 3'd1, 3'd0, 16'h4), 32'h10, 0);
    checks++; if (valid_out !== 1'b1 || opcode_out !== T_LD || rd_out !== 3'd3) begin
      errors++; $display("[TB] FAIL ld_issue: got v=%b op=%h rd=%0d expected 1/%h/3", valid_out, opcode_out, rd_out, T_LD); end
    step(0, 1, enc(T_ADD, 3'd5, 3'd3, 3'd2, 16'h0), 32'h14, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall: got %b expected 1", obs_stall); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble: got %b expected 0", valid_out); end
    step(0, 1, enc(T_ADD, 3'd5, 3'd3, 3'd2, 16'h0), 32'h14, 0);
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_release: got %b expected 0", obs_stall); end
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h14 || opcode_out !== T_ADD || rd_out !== 3'd5) begin
      errors++; $display("[TB] FAIL lu_held_issue: got v=%b pc=%h op=%h rd=%0d expected 1/14/%h/5", valid_out, pc_out, opcode_out, rd_out, T_ADD); end
    // rs2 hazard through a store, then rs2 ignored for a load
    step(0, 1, enc(T_LD, 3'd4, 3'd1, 3'd0, 16'h0), 32'h18, 0);
    step(0, 1, enc(T_ST, 3'd0, 3'd1, 3'd4, 16'h0), 32'h1C, 0);
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_rs2_stall: got %b expected 1", obs_stall); end
    step(0, 1, enc(T_ST, 3'd0, 3'd1, 3'd4, 16'h0), 32'h1C, 0);
    step(0, 1, enc(T_LD, 3'd6, 3'd1, 3'd0, 16'h0), 32'h20, 0);
    step(0, 1, enc(T_ADDI, 3'd1, 3'd2, 3'd6, 16'h0), 32'h24, 0);
    checks++; if (obs_stall !== 1'b0 || valid_out !== 1'b1) begin
      errors++; $display("[TB] FAIL lu_rs2_unused: got stall=%b v=%b expected 0/1", obs_stall, valid_out); end
  endtask

  task automatic test_branch_taken();
    step(0, 0, 0, 0, 0);
    step(0, 1, enc(T_BCOND, 3'd0, 3'd0, 3'd0, 16'h0008), 32'h100, 4'b0100);
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h108 || valid_out !== 1'b1) begin
      errors++; $display("[TB] FAIL bt_redirect: got br=%b tgt=%h v=%b expected 1/108/1", br_taken, br_target, valid_out); end
    step(0, 1, enc(T_ADD, 3'd1, 3'd2, 3'd3, 0), 32'h104, 0);
    checks++; if (valid_out !== 1'b0 || br_taken !== 1'b0) begin
      errors++; $display("[TB] FAIL bt_squash1: got v=%b br=%b expected 0/0", valid_out, br_taken); end
    step(0, 0, 0, 0, 0);
    step(0, 1, enc(T_ADD, 3'd1, 3'd2, 3'd3, 0), 32'h108, 0);
    checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL bt_squash2: got %b expected 0", valid_out); end
    step(0, 1, enc(T_ADD, 3'd1, 3'd2, 3'd3, 0), 32'h10C, 0);
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h10C) begin
      errors++; $display("[TB] FAIL bt_resume: got v=%b pc=%h expected 1/10c", valid_out, pc_out); end
  endtask

  task automatic test_branch_not_taken();
    step(0, 0, 0, 0, 0);
    step(0, 1, enc(T_BCOND, 3'd0, 3'd0, 3'd0, 16'h0008), 32'h100, 4'b0000);
    checks++; if (br_taken !== 1'b0 || valid_out !== 1'b1) begin
      errors++; $display("[TB] FAIL bnt_branch: got br=%b v=%b expected 0/1", br_taken, valid_out); end
    step(0, 1, enc(T_ADD, 3'd1, 3'd2, 3'd3, 0), 32'h104, 0);
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h104) begin
      errors++; $display("[TB] FAIL bnt_next: got v=%b pc=%h expected 1/104", valid_out, pc_out); end
  endtask

  task automatic test_branch_al_shadow();
    step(0, 0, 0, 0, 0);
    step(0, 1, enc(T_BCOND, 3'd7, 3'd0, 3'd0, 16'hFFFC), 32'h0, 4'b0000);
    checks++; if (br_taken !== 1'b1 || br_target !== 32'hFFFFFFFC) begin
      errors++; $display("[TB] FAIL al_target: got br=%b tgt=%h expected 1/fffffffc", br_taken, br_target); end
    step(0, 1, enc(T_BCOND, 3'd0, 3'd0, 3'd0, 16'h0008), 32'h4, 4'b0100);
    checks++; if (br_taken !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("[TB] FAIL al_shadow_bcond: got br=%b v=%b expected 0/0", br_taken, valid_out); end
    step(0, 1, enc(T_B, 3'd0, 3'd0, 3'd0, 0), 32'h8, 0);
    step(0, 1, enc(T_BR, 3'd0, 3'd5, 3'd0, 0), 32'hC, 4'b0100);
    checks++; if (valid_out !== 1'b1 || br_taken !== 1'b0 || opcode_out !== T_BR) begin
      errors++; $display("[TB] FAIL al_resume_br: got v=%b br=%b op=%h expected 1/0/%h", valid_out, br_taken, opcode_out, T_BR); end
  endtask

  task automatic test_reset_mid_flush();
    step(0, 0, 0, 0, 0);
    step(0, 1, enc(T_BCOND, 3'd7, 3'd0, 3'd0, 16'h0010), 32'h200, 0);
    step(1, 1, enc(T_ADD, 3'd1, 3'd2, 3'd3, 0), 32'h204, 0);
    checks++; if (valid_out !== 1'b0 || br_taken !== 1'b0 || pc_out !== 32'h0) begin
      errors++; $display("[TB] FAIL rmf_reset: got v=%b br=%b pc=%h expected 0/0/0", valid_out, br_taken, pc_out); end
    step(0, 1, enc(T_ADD, 3'd1, 3'd2, 3'd3, 0), 32'h300, 0);
    checks++; if (valid_out !== 1'b1 || pc_out !== 32'h300) begin
      errors++; $display("[TB] FAIL rmf_issue: got v=%b pc=%h expected 1/300", valid_out, pc_out); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [7];
    logic        r_v;
    logic        r_rst;
    logic [31:0] r_ins, r_pc;
    logic [3:0]  r_fl;
    ops = '{T_LD, T_ST, T_ADD, T_ADDI, T_B, T_BCOND, T_BR};
    r_pc = 32'h1000;
    r_ins = 0; r_fl = 0; r_v = 0;
    for (int i = 0; i < 600; i++) begin
      r_rst = ($urandom_range(0, 99) < 2);
      if (!exp_stall || r_rst) begin
        r_v   = ($urandom_range(0, 3) != 0);
        r_ins = enc(ops[$urandom_range(0, 6)], 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                    3'($urandom_range(0, 3)), 16'($urandom));
        r_pc  = r_pc + 32'($urandom_range(0, 2) * 4) + 32'($urandom_range(0, 1));
        r_fl  = 4'($urandom);
      end
      step(r_rst, r_v, r_ins, r_pc, r_fl);
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stall @%0d: got %b expected %b", i, obs_stall, exp_stall); end
      checks++; if (valid_out !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid @%0d: got %b expected %b", i, valid_out, m_valid); end
      checks++; if (br_taken !== m_br) begin errors++; $display("[TB] FAIL rnd_br_taken @%0d: got %b expected %b", i, br_taken, m_br); end
      if (m_br) begin
        checks++; if (br_target !== m_tgt) begin errors++; $display("[TB] FAIL rnd_br_target @%0d: got %h expected %h", i, br_target, m_tgt); end
      end
      checks++;
      if (opcode_out !== m_op || rd_out !== m_rd || rs1_out !== m_rs1 || rs2_out !== m_rs2 ||
          imm_out !== m_imm || pc_out !== m_pc) begin
        errors++;
        $display("[TB] FAIL rnd_fields @%0d: got op=%h rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h expected op=%h rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h",
                 i, opcode_out, rd_out, rs1_out, rs2_out, imm_out, pc_out, m_op, m_rd, m_rs1, m_rs2, m_imm, m_pc);
      end
`ifdef ID_PERF_CNT_EN
      checks++; if (issued_cnt !== 32'(m_issued) || bubble_cnt !== 32'(m_bubbles)) begin
        errors++; $display("[TB] FAIL rnd_perf @%0d: got %0d/%0d expected %0d/%0d", i, issued_cnt, bubble_cnt, m_issued, m_bubbles); end
`endif
    end
  endtask

  initial begin
    reset = 1'b1; instr_valid_in = 1'b0; instr_in = '0; pc_in = '0; flags_in = '0;
    m_valid = 0; m_br = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    m_imm = 0; m_pc = 0; m_tgt = 0; m_squash = 0; m_bubbled = 0;
    m_issued = 0; m_bubbles = 0; exp_stall = 0; obs_stall = 0;
    test_reset();
    test_load_use();
    test_branch_taken();
    test_branch_not_taken();
    test_branch_al_shadow();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
